// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan multiplexer.
// Segment patterns are active-high, bit order g..a.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_e;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to seven-segment decoder; non-decimal codes (10-15) light nothing.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed seven-segment scanner with a one-deep pending buffer that is
// committed to the displayed set at frame boundaries (or immediately while dark).
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 10000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ena,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_bcd,
    input  logic [NUM_DIGITS-1:0]   load_dp,
    input  logic                    lz_suppress,
    output logic [6:0]              segments,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    frame_done
);

    localparam int MAX_CNT = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
    localparam int IDX_W   = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0]      SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0]      BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] DIGIT0     = NUM_DIGITS'(1);

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    pend_full_q, pend_full_d;
    logic [4*NUM_DIGITS-1:0] pend_bcd_q, pend_bcd_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic [4*NUM_DIGITS-1:0] act_bcd_q, act_bcd_d;
    logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
    logic [6:0]              segments_q, segments_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   digit_en_q, digit_en_d;
    logic                    frame_done_q;

    logic                    frame_end;
    logic                    accept;
    logic                    commit;
    logic                    show_d;
    logic                    lead_zero;
    logic [NUM_DIGITS-1:0]   supp;
    logic [3:0]              dec_bcd;
    logic [6:0]              dec_seg;

    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        frame_end = 1'b0;
        if (!ena) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = BLANK;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
                BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = SHOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                SHOW: begin
                    if (cnt_q == SHOW_LAST) begin
                        state_d   = BLANK;
                        cnt_d     = '0;
                        frame_end = (idx_q == IDX_LAST);
                        idx_d     = frame_end ? '0 : idx_q + 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Accept and commit are mutually exclusive: accept needs an empty buffer, commit a full one.
    assign accept      = load_valid && !pend_full_q;
    assign commit      = pend_full_q && (frame_end || state_q == IDLE);
    assign pend_full_d = accept ? 1'b1 : (commit ? 1'b0 : pend_full_q);
    assign pend_bcd_d  = accept ? load_bcd : pend_bcd_q;
    assign pend_dp_d   = accept ? load_dp : pend_dp_q;
    assign act_bcd_d   = commit ? pend_bcd_q : act_bcd_q;
    assign act_dp_d    = commit ? pend_dp_q : act_dp_q;

    // Zeros are blanked from the top digit down until the first nonzero code.
    always_comb begin
        supp      = '0;
        lead_zero = lz_suppress;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (act_bcd_q[4*i +: 4] != 4'd0) lead_zero = 1'b0;
            supp[i] = lead_zero;
        end
    end

    assign dec_bcd = act_bcd_q[4*idx_d +: 4];

    seg7_decode u_decode (
        .bcd_i (dec_bcd),
        .seg_o (dec_seg)
    );

    // Outputs are computed from the next state so they switch on the same edge as the FSM.
    assign show_d     = (state_d == SHOW);
    assign digit_en_d = show_d ? (DIGIT0 << idx_d) : '0;
    assign segments_d = (show_d && !supp[idx_d]) ? dec_seg : SEG_BLANK;
    assign dp_d       = show_d && act_dp_q[idx_d];

    // NOTE: the digit buffers are reset too, so a reset always discards pending data and
    // the display restarts from a known all-zero set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            pend_full_q  <= 1'b0;
            pend_bcd_q   <= '0;
            pend_dp_q    <= '0;
            act_bcd_q    <= '0;
            act_dp_q     <= '0;
            segments_q   <= SEG_BLANK;
            dp_q         <= 1'b0;
            digit_en_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            pend_full_q  <= pend_full_d;
            pend_bcd_q   <= pend_bcd_d;
            pend_dp_q    <= pend_dp_d;
            act_bcd_q    <= act_bcd_d;
            act_dp_q     <= act_dp_d;
            segments_q   <= segments_d;
            dp_q         <= dp_d;
            digit_en_q   <= digit_en_d;
            frame_done_q <= frame_end;
        end
    end

    assign load_ready = !pend_full_q;
    assign segments   = segments_q;
    assign dp         = dp_q;
    assign digit_en   = digit_en_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Self-checking bench for seg7_scan_mux: table-driven digit sets plus directed
// sequences for buffering, enable abort and asynchronous reset.
module tb_seg7_scan_mux;

    localparam int N = 4;
    localparam int R = 8;
    localparam int B = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            ena;
    logic            load_valid;
    logic            load_ready;
    logic [4*N-1:0]  load_bcd;
    logic [N-1:0]    load_dp;
    logic            lz_suppress;
    logic [6:0]      segments;
    logic            dp;
    logic [N-1:0]    digit_en;
    logic            frame_done;

    int n_total = 0;
    int n_bad   = 0;

    typedef struct {
        logic [15:0] bcd;
        logic [3:0]  dpv;
        logic        lz;
        logic [27:0] segs;   // expected {d3,d2,d1,d0}, 7 bits each
    } vec_t;

    vec_t vecs[7];

    seg7_scan_mux #(
        .NUM_DIGITS   (N),
        .REFRESH_DIV  (R),
        .BLANK_CYCLES (B)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_bcd    (load_bcd),
        .load_dp     (load_dp),
        .lz_suppress (lz_suppress),
        .segments    (segments),
        .dp          (dp),
        .digit_en    (digit_en),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Walks one full frame starting 'lead' cycles before digit 0 lights.
    task automatic walk_frame(input int lead, input logic [27:0] segs, input logic [3:0] dps,
                              input string tag);
        logic [3:0] oh;
        repeat (lead) tick();
        for (int d = 0; d < N; d++) begin
            oh = 4'(1 << d);
            check($sformatf("%s d%0d en", tag, d), 32'(digit_en), 32'(oh));
            check($sformatf("%s d%0d seg", tag, d), 32'(segments), 32'(segs[7*d +: 7]));
            check($sformatf("%s d%0d dp", tag, d), 32'(dp), 32'(dps[d]));
            repeat (R - 1) tick();
            check($sformatf("%s d%0d still lit", tag, d), 32'(digit_en), 32'(oh));
            tick();
            check($sformatf("%s d%0d blank", tag, d), 32'({digit_en, segments, dp}), 32'(0));
            check($sformatf("%s d%0d frame_done", tag, d), 32'(frame_done), 32'(d == N - 1));
            repeat (B - 1) tick();
            check($sformatf("%s d%0d blank end", tag, d),
                  32'({digit_en, segments, dp, frame_done}), 32'(0));
            tick();
        end
    endtask

    initial begin
        bit found;
        int pulses;

        vecs[0] = '{bcd: 16'h1234, dpv: 4'b0000, lz: 1'b0, segs: {7'h06, 7'h5B, 7'h4F, 7'h66}};
        vecs[1] = '{bcd: 16'h0070, dpv: 4'b0000, lz: 1'b1, segs: {7'h00, 7'h00, 7'h07, 7'h3F}};
        vecs[2] = '{bcd: 16'h0000, dpv: 4'b0000, lz: 1'b1, segs: {7'h00, 7'h00, 7'h00, 7'h3F}};
        vecs[3] = '{bcd: 16'h5C98, dpv: 4'b0100, lz: 1'b0, segs: {7'h6D, 7'h00, 7'h6F, 7'h7F}};
        vecs[4] = '{bcd: 16'h0705, dpv: 4'b1000, lz: 1'b1, segs: {7'h00, 7'h07, 7'h3F, 7'h6D}};
        vecs[5] = '{bcd: 16'hFA03, dpv: 4'b0001, lz: 1'b1, segs: {7'h00, 7'h00, 7'h3F, 7'h4F}};
        vecs[6] = '{bcd: 16'h0006, dpv: 4'b0000, lz: 1'b0, segs: {7'h3F, 7'h3F, 7'h3F, 7'h7D}};

        rst_n       = 1'b0;
        ena         = 1'b0;
        load_valid  = 1'b0;
        load_bcd    = '0;
        load_dp     = '0;
        lz_suppress = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        check("reset segments", 32'(segments), 32'(0));
        check("reset dp", 32'(dp), 32'(0));
        check("reset digit_en", 32'(digit_en), 32'(0));
        check("reset frame_done", 32'(frame_done), 32'(0));
        check("reset load_ready", 32'(load_ready), 32'(1));

        // First frame shows the cleared set; the loaded set appears in the next one.
        ena        = 1'b1;
        load_valid = 1'b1;
        load_bcd   = 16'h1234;
        tick();
        load_valid = 1'b0;
        check("first load ready low", 32'(load_ready), 32'(0));
        walk_frame(B, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b0000, "frame1");
        check("ready after commit", 32'(load_ready), 32'(1));
        walk_frame(0, {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b0000, "frame2");

        // Back-to-back sets with load_valid held high.
        load_valid = 1'b1;
        load_bcd   = 16'h5678;
        tick();
        load_bcd = 16'h9012;
        check("b2b first accepted", 32'(load_ready), 32'(0));
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (frame_done) found = 1'b1;
            else tick();
        end
        check("b2b frame_done seen", 32'(found), 32'(1));
        check("b2b ready at boundary", 32'(load_ready), 32'(1));
        tick();
        load_valid = 1'b0;
        check("b2b second accepted", 32'(load_ready), 32'(0));
        walk_frame(B - 1, {7'h6D, 7'h7D, 7'h07, 7'h7F}, 4'b0000, "b2b set1");
        walk_frame(0, {7'h6F, 7'h3F, 7'h06, 7'h5B}, 4'b0000, "b2b set2");
        check("b2b drained", 32'(load_ready), 32'(1));

        // Table: load while dark (immediate commit), then scan one frame.
        for (int v = 0; v < 7; v++) begin
            ena = 1'b0;
            tick();
            check($sformatf("vec%0d dark", v), 32'({digit_en, segments, dp}), 32'(0));
            load_valid = 1'b1;
            load_bcd   = vecs[v].bcd;
            load_dp    = vecs[v].dpv;
            tick();
            load_valid = 1'b0;
            tick();
            check($sformatf("vec%0d idle commit", v), 32'(load_ready), 32'(1));
            lz_suppress = vecs[v].lz;
            ena         = 1'b1;
            walk_frame(B + 1, vecs[v].segs, vecs[v].dpv, $sformatf("vec%0d", v));
        end

        // Drop ena during digit 2: aborts, no frame_done, restart at digit 0.
        repeat (2 * (R + B)) tick();
        check("abort at d2", 32'(digit_en), 32'(4'b0100));
        repeat (3) tick();
        ena = 1'b0;
        tick();
        check("abort dark next cycle", 32'({digit_en, segments, dp}), 32'(0));
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (frame_done) pulses++;
        end
        check("abort no frame_done", 32'(pulses), 32'(0));
        ena = 1'b1;
        repeat (B) tick();
        check("restart still dark", 32'(digit_en), 32'(0));
        tick();
        check("restart digit 0", 32'(digit_en), 32'(4'b0001));
        check("restart seg", 32'(segments), 32'(7'h7D));

        // Async reset mid-SHOW with a full pending buffer.
        load_valid = 1'b1;
        load_bcd   = 16'h8888;
        load_dp    = 4'b1111;
        tick();
        load_valid = 1'b0;
        check("rst pending full", 32'(load_ready), 32'(0));
        check("rst pre lit", 32'(digit_en), 32'(4'b0001));
        #2;
        rst_n = 1'b0;
        #1;
        check("rst async outputs", 32'({digit_en, segments, dp, frame_done}), 32'(0));
        check("rst async ready", 32'(load_ready), 32'(1));
        @(posedge clk);
        #1;
        rst_n       = 1'b1;
        lz_suppress = 1'b0;
        check("rst release ready", 32'(load_ready), 32'(1));
        walk_frame(B + 1, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b0000, "post rst f1");
        walk_frame(0, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b0000, "post rst f2");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
